// File: rtl/rvb_vecplayer_if.sv
// rvb_vecplayer_if: din/dout valid-ready channel between a vector player
// (master) and an rvb execution unit (slave).
//   din_valid/din_ready          operand handshake, master -> slave
//   din_rs1, din_insn20/21/23    operand and instruction bits
//   dout_valid/dout_ready        result handshake, slave -> master
//   dout_rd                      result
interface rvb_vecplayer_if #(
  parameter int XLEN = 32
);
  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic            din_insn20;
  logic            din_insn21;
  logic            din_insn23;
  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;

  modport master (
    output din_valid, din_rs1, din_insn20, din_insn21, din_insn23, dout_ready,
    input  din_ready, dout_valid, dout_rd
  );

  modport slave (
    input  din_valid, din_rs1, din_insn20, din_insn21, din_insn23, dout_ready,
    output din_ready, dout_valid, dout_rd
  );
endinterface

// File: rtl/rvb_vecplayer.sv
// rvb_vecplayer: plays packed test vectors from a synchronous vector memory
// into an rvb unit and checks the unit's results against expected values.
//   clock, reset        clock; synchronous active-low reset
//   start, num_tests    begin a run of num_tests vectors (IDLE/DONE only)
//   mem_ren, mem_addr   vector memory read; mem_rdata valid one cycle later
//   unit                din/dout channel to the unit (master side)
//   busy, done          RUN/DRAIN, DONE status
//   pass_count, fail_count, first_fail, proto_err   run statistics
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching and issuing vectors
// DRAIN | all vectors issued, collecting outstanding results
// DONE  | run complete, statistics held until next start
module rvb_vecplayer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [AW:0]     num_tests,
  output logic            mem_ren,
  output logic [AW-1:0]   mem_addr,
  input  logic [159:0]    mem_rdata,
  rvb_vecplayer_if.master unit,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     pass_count,
  output logic [AW:0]     fail_count,
  output logic [AW-1:0]   first_fail,
  output logic            proto_err
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam int PW   = 2 * XLEN + 3;
  localparam logic [AW:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [AW:0]     n_reg, rp, ip;
  logic            rd_inflight;
  // prefetch entry: {rd, insn23, insn21, insn20, rs1}
  logic [PW-1:0]   pf_mem [2];
  logic            pf_wp, pf_rp;
  logic [1:0]      pf_cnt;
  logic [PW-1:0]   pf_head;
  logic [2:0]      pf_occ;
  logic [XLEN-1:0] ex_rd  [DEPTH];
  logic [AW-1:0]   ex_idx [DEPTH];
  logic [PTRW-1:0] ex_wp, ex_rp;
  logic [CW-1:0]   ex_cnt;
  logic            start_ok, din_hs, dout_hs, ex_push, ex_pop;
  logic            unused_rdata;

  assign unused_rdata = ^mem_rdata;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign pf_head  = pf_mem[pf_rp];
  assign din_hs   = unit.din_valid && unit.din_ready;
  assign dout_hs  = unit.dout_valid && unit.dout_ready;
  assign ex_push  = din_hs;
  assign ex_pop   = dout_hs && (ex_cnt != '0);

  // A slot freed by this cycle's issue counts as free, so the prefetch
  // buffer can be refilled every cycle and sustain one vector per cycle.
  assign pf_occ   = 3'(pf_cnt) + 3'(rd_inflight) - 3'(din_hs);
  assign mem_ren  = (state == RUN) && (rp < n_reg) && (pf_occ < 3'd2);
  assign mem_addr = rp[AW-1:0];

  // A full expected FIFO may still take a push when a result pops this cycle.
  assign unit.din_valid  = (pf_cnt != 2'd0) && ((ex_cnt < CW'(DEPTH)) || ex_pop);
  assign unit.din_rs1    = pf_head[XLEN-1:0];
  assign unit.din_insn20 = pf_head[XLEN];
  assign unit.din_insn21 = pf_head[XLEN+1];
  assign unit.din_insn23 = pf_head[XLEN+2];
  assign unit.dout_ready = busy;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nx = (num_tests == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (din_hs && (ip + ONE == n_reg)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // a result arriving with nothing expected is flagged before leaving
        if (ex_cnt == '0 && !unit.dout_valid) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      n_reg       <= '0;
      rp          <= '0;
      ip          <= '0;
      rd_inflight <= 1'b0;
      pf_wp       <= 1'b0;
      pf_rp       <= 1'b0;
      pf_cnt      <= 2'd0;
      ex_wp       <= '0;
      ex_rp       <= '0;
      ex_cnt      <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
      first_fail  <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      rd_inflight <= mem_ren;
      if (rd_inflight) pf_wp <= ~pf_wp;
      if (din_hs)      pf_rp <= ~pf_rp;
      pf_cnt <= pf_cnt + 2'(rd_inflight) - 2'(din_hs);
      if (ex_push) ex_wp <= ex_wp + 1'b1;
      if (ex_pop)  ex_rp <= ex_rp + 1'b1;
      ex_cnt <= ex_cnt + CW'(ex_push) - CW'(ex_pop);
      if (start_ok) begin
        n_reg      <= num_tests;
        rp         <= '0;
        ip         <= '0;
        pass_count <= '0;
        fail_count <= '0;
        first_fail <= '0;
        proto_err  <= 1'b0;
      end else begin
        if (mem_ren) rp <= rp + ONE;
        if (din_hs)  ip <= ip + ONE;
        if (dout_hs) begin
          if (ex_cnt == '0) begin
            proto_err <= 1'b1;
          end else if (unit.dout_rd == ex_rd[ex_rp]) begin
            if (pass_count != '1) pass_count <= pass_count + ONE;
          end else begin
            if (fail_count != '1) fail_count <= fail_count + ONE;
            if (fail_count == '0) first_fail <= ex_idx[ex_rp];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rd_inflight)
      pf_mem[pf_wp] <= {mem_rdata[XLEN-1:0], mem_rdata[151], mem_rdata[149],
                        mem_rdata[148], mem_rdata[64 +: XLEN]};
    if (ex_push) begin
      ex_rd[ex_wp]  <= pf_head[PW-1 -: XLEN];
      ex_idx[ex_wp] <= ip[AW-1:0];
    end
  end
endmodule
